// File: rtl/square_unit.sv
// square_unit: iterative shift-and-add squarer, PP = A*A for an N-bit
// unsigned operand. INIT/DONE handshake shared with the other calculator
// operation blocks; DONE is held for DONE_HOLD cycles before returning idle.
module square_unit #(
  parameter int N         = 16,
  parameter int DONE_HOLD = 31
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           INIT,
  input  logic [N-1:0]   A,
  output logic [2*N-1:0] PP,
  output logic           DONE,
  output logic           BUSY
);

  // Hold counter must reach DONE_HOLD-1 and is never narrower than 6 bits.
  localparam int HW = ($clog2(DONE_HOLD) > 6) ? $clog2(DONE_HOLD) : 6;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_CHECK_Z = 3'd1,
    S_CHECK   = 3'd2,
    S_ADD     = 3'd3,
    S_SHIFT   = 3'd4,
    S_END     = 3'd5
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic [2*N-1:0]  mc_r;
  logic [N-1:0]    mp_r;
  logic [2*N-1:0]  pp_r;
  logic [HW-1:0]   hcnt_r;
  logic            done_r;
  logic            busy_r;
  logic            done_s;
  logic            busy_s;
  logic            hold_last_s;

  assign hold_last_s = (hcnt_r == HW'(DONE_HOLD - 1));

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_START;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; unused encodings fall back to S_START.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_START: begin
        if (INIT) begin
          next_s = S_CHECK_Z;
        end else begin
          next_s = S_START;
        end
      end
      S_CHECK_Z: begin
        if (mp_r == {N{1'b0}}) begin
          next_s = S_END;
        end else begin
          next_s = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mp_r[0]) begin
          next_s = S_ADD;
        end else begin
          next_s = S_SHIFT;
        end
      end
      S_ADD:   next_s = S_SHIFT;
      S_SHIFT: next_s = S_CHECK_Z;
      S_END: begin
        if (hold_last_s) begin
          next_s = S_START;
        end else begin
          next_s = S_END;
        end
      end
      default: next_s = S_START;
    endcase
  end

  // Output decode from the upcoming state so DONE/BUSY can be registered
  // and still line up with the state they describe.
  always_comb begin
    done_s = 1'b0;
    busy_s = 1'b0;
    case (next_s)
      S_START: begin
        done_s = 1'b0;
        busy_s = 1'b0;
      end
      S_END: begin
        done_s = 1'b1;
        busy_s = 1'b1;
      end
      S_CHECK_Z, S_CHECK, S_ADD, S_SHIFT: begin
        done_s = 1'b0;
        busy_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= done_s;
      busy_r <= busy_s;
    end
  end

  // Datapath: operand capture, accumulate, shift and DONE hold counting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mc_r   <= {(2*N){1'b0}};
      mp_r   <= {N{1'b0}};
      pp_r   <= {(2*N){1'b0}};
      hcnt_r <= {HW{1'b0}};
    end else begin
      case (state_r)
        S_START: begin
          if (INIT) begin
            mc_r <= {{N{1'b0}}, A};
            mp_r <= A;
            pp_r <= {(2*N){1'b0}};
          end
        end
        S_CHECK_Z: begin
          if (mp_r == {N{1'b0}}) begin
            hcnt_r <= {HW{1'b0}};
          end
        end
        S_CHECK: begin
          pp_r <= pp_r;
        end
        S_ADD: begin
          // Sum of the shifted copies of A never exceeds A*A < 2^(2N).
          pp_r <= pp_r + mc_r;
        end
        S_SHIFT: begin
          mc_r <= mc_r << 1;
          mp_r <= mp_r >> 1;
        end
        S_END: begin
          hcnt_r <= hcnt_r + HW'(1);
        end
        default: begin
          mc_r   <= {(2*N){1'b0}};
          mp_r   <= {N{1'b0}};
          pp_r   <= {(2*N){1'b0}};
          hcnt_r <= {HW{1'b0}};
        end
      endcase
    end
  end

  assign PP   = pp_r;
  assign DONE = done_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_square_unit.sv
// tb_square_unit: directed and swept squaring operations, checked against a
// cycle-level behavioural model (phase + countdown derived from the latency
// formula) and against hand-computed literal results.
module tb_square_unit;

  localparam int N    = 16;
  localparam int HOLD = 31;

  logic          CLK;
  logic          RST;
  logic          INIT;
  logic [N-1:0]  A;
  logic [2*N-1:0] PP;
  logic          DONE;
  logic          BUSY;

  int n_vec;
  int n_err;

  square_unit #(.N(N), .DONE_HOLD(HOLD)) dut (
    .CLK (CLK),
    .RST (RST),
    .INIT(INIT),
    .A   (A),
    .PP  (PP),
    .DONE(DONE),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Edges from acceptance (inclusive) to entry of the result state.
  function automatic int lat_of(input logic [N-1:0] a);
    int s;
    int k;
    if (a == '0) return 2;
    k = 0;
    for (int i = 0; i < N; i++) if (a[i]) k = i;
    s = 2;
    for (int i = 0; i <= k; i++) s += 3 + int'(a[i]);
    return s;
  endfunction

  // Behavioural model: 0 = idle, 1 = computing, 2 = result held.
  int            m_phase;
  int            m_cnt;
  bit            m_valid;
  logic [2*N-1:0] m_sq;
  logic [2*N-1:0] m_idle_pp;

  initial begin
    m_valid   = 1'b0;
    m_phase   = 0;
    m_cnt     = 0;
    m_sq      = '0;
    m_idle_pp = '0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_valid   <= 1'b1;
      m_phase   <= 0;
      m_idle_pp <= '0;
    end else if (m_valid) begin
      case (m_phase)
        0: if (INIT) begin
          m_phase <= 1;
          m_sq    <= 32'(A) * 32'(A);
          m_cnt   <= lat_of(A) - 1;
        end
        1: if (m_cnt == 1) begin
          m_phase <= 2;
          m_cnt   <= HOLD;
        end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 1) begin
          m_phase   <= 0;
          m_idle_pp <= m_sq;
        end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  // Compare DUT against the model every cycle once reset has been seen.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("busy", 64'(BUSY), 64'(m_phase != 0));
      check("done", 64'(DONE), 64'(m_phase == 2));
      if (m_phase == 2)      check("pp_result", 64'(PP), 64'(m_sq));
      else if (m_phase == 0) check("pp_idle", 64'(PP), 64'(m_idle_pp));
    end
  end

  // One INIT pulse; measures latency, result and DONE length.
  task automatic run_op(input logic [N-1:0] a, input logic [2*N-1:0] exp_pp,
                        input int exp_lat, input int chg_at, input logic [N-1:0] chg_val);
    int n;
    int hold;
    @(negedge CLK);
    A    = a;
    INIT = 1'b1;
    @(negedge CLK);
    INIT = 1'b0;
    n = 1;
    while (!DONE && n < 200) begin
      if (n == chg_at) A = chg_val;
      @(negedge CLK);
      n++;
    end
    check("done_seen", 64'(DONE), 64'(1));
    check("latency", 64'(n), 64'(exp_lat));
    check("pp_final", 64'(PP), 64'(exp_pp));
    hold = 0;
    while (DONE && hold < 100) begin
      hold++;
      @(negedge CLK);
    end
    check("done_len", 64'(hold), 64'(HOLD));
    check("busy_after", 64'(BUSY), 64'(0));
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_pp", 64'(PP), 64'(0));
    check("rst_done", 64'(DONE), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
  endtask

  initial begin
    int n;
    logic [N-1:0] a;
    n_vec = 0;
    n_err = 0;
    RST   = 1'b1;
    INIT  = 1'b0;
    A     = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("reset_pp", 64'(PP), 64'(0));
    check("reset_done", 64'(DONE), 64'(0));
    check("reset_busy", 64'(BUSY), 64'(0));

    run_op(16'h0000, 32'd0, 2, 0, 16'h0000);
    run_op(16'h0001, 32'd1, 6, 0, 16'h0000);
    run_op(16'h0003, 32'd9, 10, 0, 16'h0000);
    run_op(16'h0005, 32'd25, 13, 0, 16'h0000);
    run_op(16'hFFFF, 32'hFFFE0001, 66, 5, 16'h1234);

    // INIT held high: second acceptance right after the return to idle.
    @(negedge CLK);
    A    = 16'h0002;
    INIT = 1'b1;
    @(negedge CLK);
    n = 1;
    while (!DONE && n < 200) begin @(negedge CLK); n++; end
    check("held_latency", 64'(n), 64'(9));
    check("held_pp", 64'(PP), 64'(4));
    n = 0;
    while (DONE && n < 100) begin @(negedge CLK); n++; end
    check("held_done_len", 64'(n), 64'(HOLD));
    check("held_idle_gap", 64'(BUSY), 64'(0));
    @(negedge CLK);
    check("held_reaccept", 64'(BUSY), 64'(1));
    n = 1;
    while (!DONE && n < 200) begin @(negedge CLK); n++; end
    check("held_latency2", 64'(n), 64'(9));
    check("held_pp2", 64'(PP), 64'(4));
    INIT = 1'b0;
    n = 0;
    while (BUSY && n < 100) begin @(negedge CLK); n++; end
    check("held_end_idle", 64'(BUSY), 64'(0));

    // Abort mid-computation.
    @(negedge CLK);
    A    = 16'h00FF;
    INIT = 1'b1;
    @(negedge CLK);
    INIT = 1'b0;
    repeat (8) @(negedge CLK);
    pulse_reset();
    repeat (40) @(negedge CLK);
    check("no_stray_done1", 64'(DONE), 64'(0));

    // Abort during the DONE hold.
    @(negedge CLK);
    A    = 16'h00FF;
    INIT = 1'b1;
    @(negedge CLK);
    INIT = 1'b0;
    n = 0;
    while (!DONE && n < 200) begin @(negedge CLK); n++; end
    check("abort_done_seen", 64'(DONE), 64'(1));
    check("abort_pp", 64'(PP), 64'(32'd65025));
    repeat (5) @(negedge CLK);
    pulse_reset();
    repeat (40) @(negedge CLK);
    check("no_stray_done2", 64'(DONE), 64'(0));
    run_op(16'h0007, 32'd49, 14, 0, 16'h0000);

    // Operand sweep against A*A and the latency formula.
    for (int i = 0; i < 500; i++) begin
      case (i)
        0: a = 16'h0000;
        1: a = 16'hFFFF;
        2: a = 16'h8000;
        3: a = 16'h0001;
        default: a = N'($urandom_range(0, 65535));
      endcase
      run_op(a, 32'(a) * 32'(a), lat_of(a), 0, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/square_unit.md
# square_unit

Iterative shift-and-add squaring unit for the calculator. It is the inverse operation to the square-root path. It computes PP = A·A for an N-bit unsigned operand using an internal control FSM and datapath. It uses the same INIT/DONE handshake as the other calculator operation blocks, so the top-level operation selector can start it and collect the result in the same way.

## Interface
Parameters:
- N, 16, operand width in bits; the result is 2N bits wide.
- DONE_HOLD, 31, number of cycles DONE stays high before the block returns to idle.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset. Synchronous and active-high: sampled on the CLK rising edge, it forces the reset state.
- INIT  input  1  start request; sampled only in S_START.
- A  input  N  unsigned operand; captured on the edge that accepts INIT.
- PP  output  2N  result register (partial product while busy, final square in S_END).
- DONE  output  1  high while in S_END.
- BUSY  output  1  high in every state except S_START.

## Operation
Internal registers:
- MC: 2N-bit multiplicand, shifted left once per iteration.
- MP: N-bit multiplier, shifted right once per iteration.
- PP: 2N-bit accumulator.
- HCNT: hold counter, at least 6 bits.

State machine:
- S_START: DONE=0, BUSY=0. If INIT=1: MC←{N'b0,A}, MP←A, PP←0, next state S_CHECK_Z. Otherwise stay; PP keeps its last value.
- S_CHECK_Z: if MP==0, next state S_END with HCNT←0. Otherwise next state S_CHECK.
- S_CHECK: if MP[0]=1, next state S_ADD; otherwise next state S_SHIFT.
- S_ADD: PP←PP+MC, modulo 2^2N (cannot overflow for an N-bit operand). Next state S_SHIFT.
- S_SHIFT: MC←MC<<1, MP←MP>>1. Next state S_CHECK_Z.
- S_END: DONE=1, HCNT←HCNT+1, PP held stable. When HCNT==DONE_HOLD-1, next state S_START.
- Illegal or unused state encodings go to S_START with outputs cleared.

Boundary rules:
- INIT is ignored in all states other than S_START. A level-held INIT restarts the operation only after the hold period has ended and the FSM is back in S_START.
- A is sampled once, at acceptance. Later changes to A do not affect the running computation.
- A=0: the block goes straight to S_END with PP=0.
- A=2^N-1: worst case, 4 cycles per bit.
- PP keeps the final square through S_END and in S_START until the next INIT is accepted, where it is cleared to 0.

## Timing
- Reset: RST=1 at an edge forces, after that edge, STATE=S_START, PP=0, MC=0, MP=0, HCNT=0, DONE=0, BUSY=0. RST overrides INIT and aborts any operation in progress, including during S_END. No DONE pulse is produced for an aborted operation.
- Latency from the edge that accepts INIT to the edge that enters S_END, with k = index of the highest set bit of A and b_i = bit i:
  - A≠0: 2 + Σ_{i=0..k}(3+b_i) edges.
  - A=0: 2 edges.
  - Examples: A=1 → 6; A=3 → 10; A=5 → 13; A=16'hFFFF → 66.
- BUSY rises the cycle after acceptance. It falls on the edge that returns the FSM to S_START.
- DONE is high for exactly DONE_HOLD consecutive cycles per accepted operation.
- The earliest next acceptance is the first edge after returning to S_START, with INIT=1. There is therefore at least 1 idle cycle between operations.
- Consumers sample PP only while DONE=1. Intermediate PP values are not part of the contract.

## Test plan
- Reset, then A=0, INIT pulsed for 1 cycle → DONE rises 2 edges after acceptance, PP=0, DONE high for 31 cycles, then BUSY=0.
- A=3, INIT pulse → PP=9, DONE rises 10 edges after acceptance. A=5 → PP=25 after 13 edges.
- A=16'hFFFF → PP=32'hFFFE0001 after 66 edges. Change A to 16'h1234 mid-computation → result is unchanged.
- INIT held high continuously with A=2 → PP=4. Second acceptance happens only on the first edge in S_START after the 31-cycle DONE. Extra INIT edges while busy are ignored.
- RST=1 for 1 cycle in the middle of A=16'h00FF and again during S_END → next cycle S_START, PP=0, DONE=0, BUSY=0. No stray DONE follows; the next INIT with A=7 gives PP=49.
- Random sweep of 500 operands against the reference A*A → PP and cycle count match the latency formula for every operand.
